// File: rtl/hs_cdc_rx.sv
// hs_cdc_rx: receive side of a 4-phase req/ack clock-domain crossing.
// A request level from a foreign clock domain is synchronized into clka.
// The word on data_in is captured and offered on a valid/ready interface.
// The acknowledge goes back to the sender once the local consumer takes the word.
// Optional build macro HS_CDC_SYNC3_EN: selects a 3-flop req_in synchronizer
// instead of the default 2-flop chain. This adds one edge of latency.
module hs_cdc_rx #(
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic            req_in,
  input  logic [DW-1:0]   data_in,
  output logic            ack_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic            busy,
  output logic [CNTW-1:0] xfer_cnt,
  output logic            proto_err,
  input  logic            err_clr
);

`ifdef HS_CDC_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  state_t                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [DW-1:0]          data_q, data_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   err_set;

  // Synchronizer shift: req_in is only ever observed through this chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Synchronizer flops; they clear with reset so a held request is seen as a fresh edge.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  // Next-state and datapath updates for the IDLE -> VALID -> ACK handshake.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        // Only reachable with ack low, so the sender has seen the previous ack drop.
        if (req_s) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        // The sender withdrew its request before being acknowledged.
        // Flag the violation but still deliver the word already captured.
        if (!req_s) err_set = 1'b1;
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A new violation overrides a clear on the same edge.
    err_d = err_set | (err_q & ~err_clr);
  end

  // Registered handshake state, outputs, counter and sticky error.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign ack_out   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hs_cdc_rx.sv
// Testbench for hs_cdc_rx: table of directed transfers, hand-written reset
// sequences, then a randomized stream with a sender on an unrelated clock.
// The counter is narrowed to 4 bits so that the wrap case is reached quickly.
`timescale 1ns/1ps
module tb_hs_cdc_rx;

`ifdef HS_CDC_SYNC3_EN
  localparam int SYNC = 3;
`else
  localparam int SYNC = 2;
`endif
  localparam int LAT  = SYNC + 1;
  localparam int CNTW = 4;

  logic            clka = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_in = 1'b0;
  logic [7:0]      data_in = 8'h00;
  logic            ack_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      out_data;
  logic            busy;
  logic [CNTW-1:0] xfer_cnt;
  logic            proto_err;
  logic            err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [CNTW-1:0] exp_cnt = '0;

  logic sclk = 1'b0;
  real  sper = 30.0;
  logic [7:0] exp_q[$];

  hs_cdc_rx #(.DW(8), .CNTW(CNTW)) dut (
    .clka(clka), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
    .ack_out(ack_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .xfer_cnt(xfer_cnt),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  always #5 clka = ~clka;
  initial begin
    #1.7;
    forever #(sper / 2.0) sclk = ~sclk;
  end

  typedef struct {
    logic [7:0] data;
    int         rdy_dly;
    bit         drop;
    bit         clr_during;
    bit         clr_after;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // One full handshake driven from the bench in clka time.
  task automatic do_xfer(input vec_t v);
    int n;
    data_in = v.data;
    req_in  = 1'b1;
    out_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 12);
    chk("latency", n, LAT);
    chk("capture", out_data, v.data);
    chk("busy_valid", busy, 1);
    if (v.drop) begin
      req_in = 1'b0;
      err_clr = v.clr_during;
      repeat (SYNC + 1) tick();
      err_clr = 1'b0;
      chk("err_set", proto_err, 1);
      chk("valid_after_drop", out_valid, 1);
    end
    for (int i = 0; i < v.rdy_dly; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, v.data);
      chk("bp_ack", ack_out, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("done_valid", out_valid, 0);
    chk("done_ack", ack_out, 1);
    chk("xfer_cnt", xfer_cnt, exp_cnt);
    if (v.drop) begin
      tick();
      chk("ack_fast_drop", ack_out, 0);
    end else begin
      req_in = 1'b0;
      n = 0;
      do begin tick(); n++; end while (ack_out && n < 12);
      chk("ack_release", n, LAT);
    end
    chk("busy_idle", busy, 0);
    chk("err_state", proto_err, v.exp_err);
    if (v.clr_after) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", proto_err, 0);
    end
  endtask

  // Sender on its own clock: full 4-phase handshake per word.
  task automatic sender(input int n);
    int k;
    logic [7:0] w;
    for (int i = 0; i < n; i++) begin
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      @(posedge sclk);
      data_in = w;
      req_in  = 1'b1;
      k = 0;
      while (!ack_out && k < 5000) begin @(posedge sclk); k++; end
      if (k >= 5000) begin chk("snd_ack_timeout", 1, 0); return; end
      req_in = 1'b0;
      k = 0;
      while (ack_out && k < 5000) begin @(posedge sclk); k++; end
      if (k >= 5000) begin chk("snd_rel_timeout", 1, 0); return; end
    end
  endtask

  // Random-ready consumer; a word is taken on the edge after valid&ready is seen.
  task automatic receiver(input int n);
    int got = 0;
    int guard = 0;
    logic [7:0] e;
    while (got < n && guard < 30000) begin
      @(negedge clka);
      guard++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("stream_word", out_data, e);
        exp_cnt = exp_cnt + 1'b1;
        got++;
      end
    end
    if (got < n) chk("stream_timeout", got, n);
    @(negedge clka);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0] = '{data: 8'hA5, rdy_dly: 0,  drop: 0, clr_during: 0, clr_after: 0, exp_err: 0};
    vecs[1] = '{data: 8'h5A, rdy_dly: 10, drop: 0, clr_during: 0, clr_after: 0, exp_err: 0};
    vecs[2] = '{data: 8'hFF, rdy_dly: 0,  drop: 1, clr_during: 0, clr_after: 1, exp_err: 1};
    vecs[3] = '{data: 8'h00, rdy_dly: 2,  drop: 0, clr_during: 0, clr_after: 0, exp_err: 0};
    vecs[4] = '{data: 8'h3C, rdy_dly: 1,  drop: 1, clr_during: 1, clr_after: 1, exp_err: 1};

    // Reset state
    #3;
    chk("rst_ack", ack_out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_cnt, 0);
    chk("rst_err", proto_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Counter wrap: bring the total to 2**CNTW transfers.
    for (int i = 5; i < 16; i++)
      do_xfer('{data: 8'(i * 17), rdy_dly: 0, drop: 0, clr_during: 0, clr_after: 0, exp_err: 0});
    chk("wrap_cnt", xfer_cnt, 0);
    chk("wrap_err", proto_err, 0);
    chk("wrap_valid", out_valid, 0);

    // Reset while in VALID, released with the request still high.
    data_in = 8'h77;
    req_in  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 12);
    chk("rv_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rv_ack", ack_out, 0);
    chk("rv_valid_low", out_valid, 0);
    chk("rv_busy", busy, 0);
    chk("rv_cnt", xfer_cnt, 0);
    chk("rv_err", proto_err, 0);
    exp_cnt = '0;
    data_in = 8'h3C;
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 12);
    chk("rr_latency", n, LAT);
    chk("rr_data", out_data, 8'h3C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("rr_cnt", xfer_cnt, exp_cnt);
    chk("rr_ack", ack_out, 1);

    // Reset while in ACK: ack drops immediately, no error.
    #2 rst_n = 1'b0;
    req_in = 1'b0;
    #1;
    chk("ra_ack", ack_out, 0);
    chk("ra_busy", busy, 0);
    chk("ra_err", proto_err, 0);
    exp_cnt = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("ra_idle_valid", out_valid, 0);

    // Random streams at three clock ratios.
    sper = 30.0;
    fork sender(300); receiver(300); join
    sper = 10.0 / 3.0;
    fork sender(400); receiver(400); join
    sper = 10.0;
    fork sender(300); receiver(300); join
    tick();
    chk("stream_err", proto_err, 0);
    chk("stream_cnt", xfer_cnt, exp_cnt);
    chk("stream_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
